exc_ctrl: RTL and testbench

Exception/interrupt controller between the WB stage and the CSR file. It qualifies each retiring WB instruction against its exception flags and the pending-interrupt condition, and selects the highest-priority cause. It drives the CSR file's exception/ertn write port with single-cycle pulses and sequences the pipeline redirect to EENTRY or ERA through a valid/ready handshake with IF. It then squashes wrong-path retirements for a fixed hold window.

---
 rtl/cpu_exc_pkg.sv | 30 +++
 rtl/exc_prio_enc.sv | 38 +++
 rtl/exc_ctrl.sv | 157 +++++++++++++++
 tb/tb_exc_ctrl.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_exc_pkg.sv
// Shared exception-controller definitions: cause encodings, flag bit positions,
// controller FSM encoding and the interrupt-pending reduction.
package cpu_exc_pkg;

  localparam logic [5:0] ECODE_INT  = 6'h00;
  localparam logic [5:0] ECODE_ADEF = 6'h08;
  localparam logic [5:0] ECODE_ALE  = 6'h09;
  localparam logic [5:0] ECODE_SYS  = 6'h0B;
  localparam logic [5:0] ECODE_BRK  = 6'h0C;
  localparam logic [5:0] ECODE_INE  = 6'h0D;

  localparam logic [8:0] ESUBCODE_NONE = 9'h000;
  localparam logic [8:0] ESUBCODE_ADEF = 9'h000;

  // Bit positions inside wb_exc_flags = {ine, brk, sys, ale, adef}
  localparam int FLAG_ADEF = 0;
  localparam int FLAG_ALE  = 1;
  localparam int FLAG_SYS  = 2;
  localparam int FLAG_BRK  = 3;
  localparam int FLAG_INE  = 4;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_REDIRECT = 2'd1;
  localparam logic [1:0] ST_HOLD     = 2'd2;

  function automatic logic int_pending(input logic ie, input logic [12:0] is, input logic [12:0] lie);
    return ie & (|(is & lie));
  endfunction

endpackage

// File: rtl/exc_prio_enc.sv
// Combinational cause arbiter: picks the single highest-priority cause
// (INT > ADEF > INE > SYS > BRK > ALE > ERTN) for the retiring instruction.
module exc_prio_enc
  import cpu_exc_pkg::*;
(
  input  logic       i_int_pend,
  input  logic [4:0] i_flags,
  input  logic       i_ertn,
  output logic       o_take_ex,
  output logic       o_take_ertn,
  output logic [5:0] o_ecode,
  output logic [8:0] o_esubcode
);

  // Cause selection; ERTN only wins when nothing else is raised
  always_comb begin
    o_take_ex   = i_int_pend | (|i_flags);
    o_take_ertn = i_ertn & ~o_take_ex;
    o_esubcode  = ESUBCODE_NONE;
    if (i_int_pend) begin
      o_ecode = ECODE_INT;
    end else if (i_flags[FLAG_ADEF]) begin
      o_ecode    = ECODE_ADEF;
      o_esubcode = ESUBCODE_ADEF;
    end else if (i_flags[FLAG_INE]) begin
      o_ecode = ECODE_INE;
    end else if (i_flags[FLAG_SYS]) begin
      o_ecode = ECODE_SYS;
    end else if (i_flags[FLAG_BRK]) begin
      o_ecode = ECODE_BRK;
    end else if (i_flags[FLAG_ALE]) begin
      o_ecode = ECODE_ALE;
    end else begin
      o_ecode = ECODE_INT;
    end
  end

endmodule

// File: rtl/exc_ctrl.sv
// Exception/interrupt controller between WB and the CSR file: arbitrates causes,
// pulses the CSR exception/ertn port and sequences the IF redirect plus squash window.
module exc_ctrl
  import cpu_exc_pkg::*;
#(
  parameter int FLUSH_HOLD = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        wb_valid,
  output logic        wb_ready,
  output logic        wb_cancel,
  input  logic [31:0] wb_pc,
  input  logic [31:0] wb_vaddr,
  input  logic [4:0]  wb_exc_flags,
  input  logic        wb_ertn,
  input  logic        csr_crmd_ie,
  input  logic [12:0] csr_estat_is,
  input  logic [12:0] csr_ecfg_lie,
  input  logic [31:0] csr_eentry,
  input  logic [31:0] csr_era,
  output logic        ex_pulse,
  output logic [5:0]  ex_ecode,
  output logic [8:0]  ex_esubcode,
  output logic [31:0] ex_pc,
  output logic [31:0] ex_vaddr,
  output logic        ertn_pulse,
  output logic        flush_valid,
  input  logic        flush_ready,
  output logic [31:0] flush_target
);

  localparam logic [3:0] HOLD_INIT = 4'(FLUSH_HOLD - 1);

  logic [1:0]  r_state;
  logic [3:0]  r_cnt;
  logic        r_int_pend;
  logic        r_wb_ready;
  logic        r_ex_pulse;
  logic        r_ertn_pulse;
  logic        r_flush_valid;
  logic [31:0] r_flush_target;
  logic [5:0]  r_ex_ecode;
  logic [8:0]  r_ex_esubcode;
  logic [31:0] r_ex_pc;
  logic [31:0] r_ex_vaddr;

  logic        w_accept;
  logic        w_take_ex;
  logic        w_take_ertn;
  logic        w_ex_acc;
  logic        w_ertn_acc;
  logic [5:0]  w_ecode;
  logic [8:0]  w_esubcode;
  logic [1:0]  w_next_state;
  logic [3:0]  w_next_cnt;

  exc_prio_enc u_prio (
    .i_int_pend  (r_int_pend),
    .i_flags     (wb_exc_flags),
    .i_ertn      (wb_ertn),
    .o_take_ex   (w_take_ex),
    .o_take_ertn (w_take_ertn),
    .o_ecode     (w_ecode),
    .o_esubcode  (w_esubcode)
  );

  assign w_accept   = wb_valid & r_wb_ready;
  assign w_ex_acc   = w_accept & w_take_ex;
  assign w_ertn_acc = w_accept & w_take_ertn;
  assign wb_cancel  = w_accept & (r_int_pend | (|wb_exc_flags));

  assign wb_ready     = r_wb_ready;
  assign ex_pulse     = r_ex_pulse;
  assign ertn_pulse   = r_ertn_pulse;
  assign flush_valid  = r_flush_valid;
  assign flush_target = r_flush_target;
  assign ex_ecode     = r_ex_ecode;
  assign ex_esubcode  = r_ex_esubcode;
  assign ex_pc        = r_ex_pc;
  assign ex_vaddr     = r_ex_vaddr;

  // Redirect/hold sequencing
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_ex_acc | w_ertn_acc) begin
          w_next_state = ST_REDIRECT;
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_REDIRECT: begin
        if (flush_ready) begin
          w_next_state = ST_HOLD;
          w_next_cnt   = HOLD_INIT;
        end else begin
          w_next_state = ST_REDIRECT;
        end
      end
      ST_HOLD: begin
        if (r_cnt == 4'd0) begin
          w_next_state = ST_IDLE;
        end else begin
          w_next_cnt = r_cnt - 4'd1;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
        w_next_cnt   = 4'd0;
      end
    endcase
  end

  // State, handshake outputs and interrupt sampling; ready/valid are decoded from the next state
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state       <= ST_IDLE;
      r_cnt         <= 4'd0;
      r_int_pend    <= 1'b0;
      r_wb_ready    <= 1'b0;
      r_flush_valid <= 1'b0;
      r_ex_pulse    <= 1'b0;
      r_ertn_pulse  <= 1'b0;
    end else begin
      r_state       <= w_next_state;
      r_cnt         <= w_next_cnt;
      r_int_pend    <= int_pending(csr_crmd_ie, csr_estat_is, csr_ecfg_lie);
      r_wb_ready    <= (w_next_state == ST_IDLE);
      r_flush_valid <= (w_next_state == ST_REDIRECT);
      r_ex_pulse    <= w_ex_acc;
      r_ertn_pulse  <= w_ertn_acc;
    end
  end

  // Cause record and redirect target, captured only on the accepting cycle
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_flush_target <= 32'h0000_0000;
      r_ex_ecode     <= 6'h00;
      r_ex_esubcode  <= 9'h000;
      r_ex_pc        <= 32'h0000_0000;
      r_ex_vaddr     <= 32'h0000_0000;
    end else if (w_ex_acc) begin
      r_flush_target <= csr_eentry;
      r_ex_ecode     <= w_ecode;
      r_ex_esubcode  <= w_esubcode;
      r_ex_pc        <= wb_pc;
      r_ex_vaddr     <= (w_ecode == ECODE_ADEF) ? wb_pc : wb_vaddr;
    end else if (w_ertn_acc) begin
      r_flush_target <= csr_era;
    end
  end

endmodule

// File: tb/tb_exc_ctrl.sv
// Self-checking bench for exc_ctrl: directed scenarios plus a randomized run
// scored against a cycle-level behavioural model of the controller's rules.
module tb_exc_ctrl;

  localparam int FLUSH_HOLD = 2;

  logic        clk = 1'b0;
  logic        resetn;
  logic        wb_valid;
  logic        wb_ready;
  logic        wb_cancel;
  logic [31:0] wb_pc;
  logic [31:0] wb_vaddr;
  logic [4:0]  wb_exc_flags;
  logic        wb_ertn;
  logic        csr_crmd_ie;
  logic [12:0] csr_estat_is;
  logic [12:0] csr_ecfg_lie;
  logic [31:0] csr_eentry;
  logic [31:0] csr_era;
  logic        ex_pulse;
  logic [5:0]  ex_ecode;
  logic [8:0]  ex_esubcode;
  logic [31:0] ex_pc;
  logic [31:0] ex_vaddr;
  logic        ertn_pulse;
  logic        flush_valid;
  logic        flush_ready;
  logic [31:0] flush_target;

  int n_cmp = 0;
  int n_bad = 0;

  exc_ctrl #(.FLUSH_HOLD(FLUSH_HOLD)) dut (
    .clk(clk), .resetn(resetn),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_cancel(wb_cancel),
    .wb_pc(wb_pc), .wb_vaddr(wb_vaddr), .wb_exc_flags(wb_exc_flags), .wb_ertn(wb_ertn),
    .csr_crmd_ie(csr_crmd_ie), .csr_estat_is(csr_estat_is), .csr_ecfg_lie(csr_ecfg_lie),
    .csr_eentry(csr_eentry), .csr_era(csr_era),
    .ex_pulse(ex_pulse), .ex_ecode(ex_ecode), .ex_esubcode(ex_esubcode),
    .ex_pc(ex_pc), .ex_vaddr(ex_vaddr), .ertn_pulse(ertn_pulse),
    .flush_valid(flush_valid), .flush_ready(flush_ready), .flush_target(flush_target)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference cause priority, straight from the ordering rule
  function automatic logic [5:0] ref_ecode(input bit pend, input logic [4:0] f);
    if (pend)      return 6'h00;
    if (f[0])      return 6'h08;
    if (f[4])      return 6'h0D;
    if (f[2])      return 6'h0B;
    if (f[3])      return 6'h0C;
    return 6'h09;
  endfunction

  task automatic drain();
    int n = 0;
    wb_valid = 1'b0;
    flush_ready = 1'b1;
    while (wb_ready !== 1'b1 && n < 40) begin
      tick();
      n++;
    end
    flush_ready = 1'b0;
    n_cmp++;
    if (wb_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL drain_timeout: wb_ready=%b required 1 within 40 cycles", wb_ready);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #2;
    n_cmp++; if (wb_ready !== 1'b0) begin n_bad++; $display("FAIL reset_wb_ready: got %b want 0", wb_ready); end
    n_cmp++; if ({ex_pulse, ertn_pulse, flush_valid} !== 3'b000) begin n_bad++; $display("FAIL reset_pulses: got %b want 000", {ex_pulse, ertn_pulse, flush_valid}); end
    n_cmp++; if ({flush_target, ex_pc, ex_vaddr} !== 96'h0) begin n_bad++; $display("FAIL reset_regs: got %h want 0", {flush_target, ex_pc, ex_vaddr}); end
    @(negedge clk);
    resetn = 1'b1;
    tick();
    n_cmp++; if (wb_ready !== 1'b1) begin n_bad++; $display("FAIL reset_release_ready: got %b want 1", wb_ready); end
  endtask

  task automatic test_interrupt();
    csr_crmd_ie = 1'b1; csr_ecfg_lie = 13'h800; csr_estat_is = 13'h800;
    csr_eentry = 32'h1c00_8000;
    tick();
    wb_valid = 1'b1; wb_pc = 32'h1c00_0100; wb_exc_flags = 5'b00000; wb_ertn = 1'b0;
    #1;
    n_cmp++; if (wb_cancel !== 1'b1) begin n_bad++; $display("FAIL int_cancel: got %b want 1", wb_cancel); end
    tick();
    wb_valid = 1'b0; csr_estat_is = 13'h000;
    n_cmp++; if (ex_pulse !== 1'b1 || ertn_pulse !== 1'b0) begin n_bad++; $display("FAIL int_pulse: ex=%b ertn=%b want 1/0", ex_pulse, ertn_pulse); end
    n_cmp++; if (ex_ecode !== 6'h00 || ex_esubcode !== 9'h000) begin n_bad++; $display("FAIL int_ecode: got %h/%h want 00/000", ex_ecode, ex_esubcode); end
    n_cmp++; if (ex_pc !== 32'h1c00_0100) begin n_bad++; $display("FAIL int_ex_pc: got %h want 1c000100", ex_pc); end
    n_cmp++; if (flush_valid !== 1'b1 || flush_target !== 32'h1c00_8000) begin n_bad++; $display("FAIL int_flush: valid=%b tgt=%h want 1/1c008000", flush_valid, flush_target); end
    flush_ready = 1'b1;
    tick();
    flush_ready = 1'b0;
    n_cmp++; if ({ex_pulse, flush_valid, wb_ready} !== 3'b000) begin n_bad++; $display("FAIL int_hold1: ex/fv/rdy=%b want 000", {ex_pulse, flush_valid, wb_ready}); end
    tick();
    n_cmp++; if (wb_ready !== 1'b0) begin n_bad++; $display("FAIL int_hold2: wb_ready=%b want 0", wb_ready); end
    tick();
    n_cmp++; if (wb_ready !== 1'b1) begin n_bad++; $display("FAIL int_ready_back: wb_ready=%b want 1", wb_ready); end
  endtask

  task automatic test_multi_flag();
    wb_valid = 1'b1; wb_pc = 32'h1c00_0040; wb_vaddr = 32'h1000_0003;
    wb_exc_flags = 5'b00110; wb_ertn = 1'b1;
    #1;
    n_cmp++; if (wb_cancel !== 1'b1) begin n_bad++; $display("FAIL multi_cancel: got %b want 1", wb_cancel); end
    tick();
    wb_valid = 1'b0; wb_exc_flags = 5'b00000; wb_ertn = 1'b0;
    n_cmp++; if (ex_pulse !== 1'b1 || ertn_pulse !== 1'b0) begin n_bad++; $display("FAIL multi_pulse: ex=%b ertn=%b want 1/0", ex_pulse, ertn_pulse); end
    n_cmp++; if (ex_ecode !== 6'h0B || ex_vaddr !== 32'h1000_0003) begin n_bad++; $display("FAIL multi_ecode: got %h/%h want 0b/10000003", ex_ecode, ex_vaddr); end
    tick();
    n_cmp++; if (ex_pulse !== 1'b0) begin n_bad++; $display("FAIL multi_single: ex_pulse=%b want 0", ex_pulse); end
    drain();
  endtask

  task automatic test_adef();
    wb_valid = 1'b1; wb_pc = 32'h1c00_0002; wb_vaddr = 32'hdead_beef; wb_exc_flags = 5'b00001;
    tick();
    wb_valid = 1'b0; wb_exc_flags = 5'b00000;
    n_cmp++; if (ex_pulse !== 1'b1 || ex_ecode !== 6'h08 || ex_esubcode !== 9'h000) begin n_bad++; $display("FAIL adef_code: ex=%b ecode=%h esub=%h want 1/08/000", ex_pulse, ex_ecode, ex_esubcode); end
    n_cmp++; if (ex_vaddr !== 32'h1c00_0002) begin n_bad++; $display("FAIL adef_vaddr: got %h want 1c000002", ex_vaddr); end
    drain();
  endtask

  task automatic test_ertn_stall();
    csr_era = 32'h1c00_0204;
    wb_valid = 1'b1; wb_ertn = 1'b1; wb_exc_flags = 5'b00000; flush_ready = 1'b0;
    #1;
    n_cmp++; if (wb_cancel !== 1'b0) begin n_bad++; $display("FAIL ertn_cancel: got %b want 0", wb_cancel); end
    tick();
    wb_valid = 1'b0; wb_ertn = 1'b0; csr_era = 32'h0bad_0000;
    for (int i = 0; i < 5; i++) begin
      n_cmp++; if (flush_valid !== 1'b1 || flush_target !== 32'h1c00_0204 || wb_ready !== 1'b0) begin
        n_bad++; $display("FAIL ertn_stall_%0d: fv=%b tgt=%h rdy=%b want 1/1c000204/0", i, flush_valid, flush_target, wb_ready);
      end
      n_cmp++; if (ertn_pulse !== (i == 0) || ex_pulse !== 1'b0) begin
        n_bad++; $display("FAIL ertn_pulse_%0d: ertn=%b ex=%b want %0d/0", i, ertn_pulse, ex_pulse, (i == 0));
      end
      if (i == 4) flush_ready = 1'b1;
      tick();
    end
    flush_ready = 1'b0;
    for (int i = 0; i < FLUSH_HOLD; i++) begin
      n_cmp++; if (wb_ready !== 1'b0 || flush_valid !== 1'b0) begin n_bad++; $display("FAIL ertn_hold_%0d: rdy=%b fv=%b want 0/0", i, wb_ready, flush_valid); end
      tick();
    end
    n_cmp++; if (wb_ready !== 1'b1) begin n_bad++; $display("FAIL ertn_ready_back: got %b want 1", wb_ready); end
  endtask

  task automatic test_int_during_hold();
    csr_era = 32'h1c00_0300; csr_eentry = 32'h1c00_8000;
    wb_valid = 1'b1; wb_ertn = 1'b1; wb_pc = 32'h1c00_0500;
    tick();
    wb_valid = 1'b0; wb_ertn = 1'b0; flush_ready = 1'b1;
    tick();
    flush_ready = 1'b0;
    csr_crmd_ie = 1'b1; csr_ecfg_lie = 13'h004; csr_estat_is = 13'h004;
    for (int i = 0; i < FLUSH_HOLD; i++) begin
      n_cmp++; if (ex_pulse !== 1'b0 || wb_ready !== 1'b0) begin n_bad++; $display("FAIL hold_int_%0d: ex=%b rdy=%b want 0/0", i, ex_pulse, wb_ready); end
      tick();
    end
    tick();
    n_cmp++; if (ex_pulse !== 1'b0 || flush_valid !== 1'b0) begin n_bad++; $display("FAIL empty_wb_int: ex=%b fv=%b want 0/0", ex_pulse, flush_valid); end
    wb_valid = 1'b1; wb_pc = 32'h1c00_0600;
    #1;
    n_cmp++; if (wb_cancel !== 1'b1) begin n_bad++; $display("FAIL late_int_cancel: got %b want 1", wb_cancel); end
    tick();
    wb_valid = 1'b0; csr_estat_is = 13'h000;
    n_cmp++; if (ex_pulse !== 1'b1 || ex_ecode !== 6'h00 || ex_pc !== 32'h1c00_0600) begin n_bad++; $display("FAIL late_int_take: ex=%b ecode=%h pc=%h want 1/00/1c000600", ex_pulse, ex_ecode, ex_pc); end
    drain();
  endtask

  task automatic test_reset_mid_redirect();
    wb_valid = 1'b1; wb_exc_flags = 5'b01000; flush_ready = 1'b0;
    tick();
    wb_valid = 1'b0; wb_exc_flags = 5'b00000;
    tick();
    n_cmp++; if (flush_valid !== 1'b1) begin n_bad++; $display("FAIL mid_redirect_pre: fv=%b want 1", flush_valid); end
    #2;
    resetn = 1'b0;
    #1;
    n_cmp++; if (flush_valid !== 1'b0 || wb_ready !== 1'b0) begin n_bad++; $display("FAIL mid_reset_async: fv=%b rdy=%b want 0/0", flush_valid, wb_ready); end
    tick();
    @(negedge clk);
    resetn = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if ({ex_pulse, ertn_pulse, flush_valid, wb_ready} !== 4'b0001) begin
        n_bad++; $display("FAIL post_reset_%0d: ex/ertn/fv/rdy=%b want 0001", i, {ex_pulse, ertn_pulse, flush_valid, wb_ready});
      end
      tick();
    end
  endtask

  task automatic test_random();
    bit          m_redirect = 1'b0;
    int          m_ready_at = 0;
    bit          m_pend;
    bit          m_ex = 1'b0;
    bit          m_ertn = 1'b0;
    bit          rdy;
    logic [31:0] m_target = 32'h0;
    logic [31:0] m_pc = 32'h0;
    logic [31:0] m_vaddr = 32'h0;
    logic [5:0]  m_ecode = 6'h0;
    m_pend = csr_crmd_ie & (|(csr_estat_is & csr_ecfg_lie));
    for (int c = 0; c < 600; c++) begin
      wb_valid     = ($urandom_range(0, 1) == 1);
      wb_exc_flags = ($urandom_range(0, 1) == 1) ? 5'($urandom) : 5'b00000;
      wb_ertn      = ($urandom_range(0, 3) == 0);
      wb_pc        = $urandom;
      wb_vaddr     = $urandom;
      csr_crmd_ie  = ($urandom_range(0, 1) == 1);
      csr_estat_is = ($urandom_range(0, 4) == 0) ? (13'h1 << $urandom_range(0, 12)) : 13'h0;
      csr_ecfg_lie = 13'($urandom);
      csr_eentry   = $urandom;
      csr_era      = $urandom;
      flush_ready  = ($urandom_range(0, 2) == 0);
      #1;
      rdy = !m_redirect && (c >= m_ready_at);
      n_cmp++; if (wb_ready !== rdy) begin n_bad++; $display("FAIL rnd_ready c=%0d: got %b want %b", c, wb_ready, rdy); end
      n_cmp++; if (wb_cancel !== (wb_valid & rdy & (m_pend | (|wb_exc_flags)))) begin
        n_bad++; $display("FAIL rnd_cancel c=%0d: got %b want %b", c, wb_cancel, wb_valid & rdy & (m_pend | (|wb_exc_flags)));
      end
      n_cmp++; if (ex_pulse !== m_ex || ertn_pulse !== m_ertn) begin n_bad++; $display("FAIL rnd_pulse c=%0d: ex=%b ertn=%b want %b/%b", c, ex_pulse, ertn_pulse, m_ex, m_ertn); end
      n_cmp++; if (flush_valid !== m_redirect) begin n_bad++; $display("FAIL rnd_fvalid c=%0d: got %b want %b", c, flush_valid, m_redirect); end
      if (m_redirect) begin
        n_cmp++; if (flush_target !== m_target) begin n_bad++; $display("FAIL rnd_target c=%0d: got %h want %h", c, flush_target, m_target); end
      end
      if (m_ex) begin
        n_cmp++; if (ex_ecode !== m_ecode || ex_esubcode !== 9'h000 || ex_pc !== m_pc || ex_vaddr !== m_vaddr) begin
          n_bad++; $display("FAIL rnd_cause c=%0d: ecode=%h esub=%h pc=%h va=%h want %h/000/%h/%h", c, ex_ecode, ex_esubcode, ex_pc, ex_vaddr, m_ecode, m_pc, m_vaddr);
        end
      end
      m_ex = 1'b0;
      m_ertn = 1'b0;
      if (m_redirect && flush_ready) begin
        m_redirect = 1'b0;
        m_ready_at = c + 1 + FLUSH_HOLD;
      end else if (wb_valid && rdy) begin
        if (m_pend || wb_exc_flags != 5'b00000) begin
          m_ex = 1'b1; m_redirect = 1'b1;
          m_ecode = ref_ecode(m_pend, wb_exc_flags);
          m_pc = wb_pc;
          m_vaddr = (m_ecode == 6'h08) ? wb_pc : wb_vaddr;
          m_target = csr_eentry;
        end else if (wb_ertn) begin
          m_ertn = 1'b1; m_redirect = 1'b1;
          m_target = csr_era;
        end
      end
      m_pend = csr_crmd_ie & (|(csr_estat_is & csr_ecfg_lie));
      tick();
    end
    csr_estat_is = 13'h000;
    drain();
  endtask

  initial begin
    resetn = 1'b0;
    wb_valid = 1'b0; wb_pc = 32'h0; wb_vaddr = 32'h0; wb_exc_flags = 5'b00000; wb_ertn = 1'b0;
    csr_crmd_ie = 1'b0; csr_estat_is = 13'h000; csr_ecfg_lie = 13'h000;
    csr_eentry = 32'h1c00_8000; csr_era = 32'h0; flush_ready = 1'b0;
    test_reset();
    test_interrupt();
    test_multi_flag();
    test_adef();
    test_ertn_stall();
    test_int_during_hold();
    test_reset_mid_redirect();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
